bht_sat_table: RTL
==================

Name: bht_sat_table

Overview:
- Branch history table of DEPTH parametrised saturating up/down counters. One counter per index.
- Supplies taken/not-taken predictions to the fetch stage and is trained by branch resolution in execute.
- Generalises the single 2-bit saturating counter to WIDTH bits with indexed storage, a registered predict port, a resolve/update port, same-cycle bypass and an init sweep FSM.
- Sits between the IF-stage PC mux and the EX-stage branch compare.

Parameters:
- WIDTH, 2: counter width in bits; value range 0..2^WIDTH-1.
- INDEX_BITS, 6: table index width; DEPTH = 2^INDEX_BITS entries.
- INIT_VAL, 2^(WIDTH-1)-1: value written to each entry during the init sweep (weakly not-taken).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pred_valid  in  1  prediction request this cycle.
- pred_pc  in  32  PC of the branch being predicted.
- pred_out_valid  out  1  prediction result valid; one cycle after the accepted request.
- pred_taken  out  1  MSB of the predicted counter.
- pred_ctr  out  WIDTH  full counter value for the prediction.
- upd_valid  in  1  resolved branch update this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction: 1 = taken, 0 = not taken.
- busy  out  1  high while the init sweep is running.

Behaviour:
- Index mapping: idx = pc[INDEX_BITS+1:2] for both ports. Word-aligned PCs that differ only above bit INDEX_BITS+1 alias to the same entry; aliasing is intended.
- Counter encoding is unsigned. taken = MSB.
- Update rule:
  - upd_taken=1: ctr <= (ctr == 2^WIDTH-1) ? ctr : ctr+1.
  - upd_taken=0: ctr <= (ctr == 0) ? 0 : ctr-1.
  - No wrap-around in either direction.
- FSM states: INIT, RUN.
- While rst_n=0:
  - state <= INIT, sweep pointer <= 0.
  - pred_out_valid, pred_taken, pred_ctr all 0; busy=1.
- INIT (rst_n=1):
  - Each cycle writes INIT_VAL to entry[ptr], then ptr <= ptr+1.
  - After the write to entry DEPTH-1: state <= RUN.
  - busy=1 for exactly DEPTH cycles after rst_n rises, then 0.
  - pred_valid and upd_valid are ignored in INIT; pred_out_valid stays 0.
- RUN predict path:
  - pred_valid=1 at edge N -> pred_out_valid=1, pred_taken and pred_ctr valid after edge N.
  - pred_out_valid=0 in any cycle following a cycle with pred_valid=0.
  - Outputs hold their last values when pred_out_valid=0.
- RUN update path: upd_valid=1 performs the read-modify-write of entry[upd_idx] in a single edge.
- Bypass: pred_valid and upd_valid in the same cycle with equal idx -> the prediction returns the post-update counter value, not the stale one.
- Reset mid-sweep or mid-run: rst_n=0 at any edge aborts the operation; the full sweep restarts from index 0 after release. Table contents are not otherwise cleared.
- No back-pressure: one predict and one update accepted per cycle in RUN.

Optional Feature:
- Macro: BHT_GSHARE_EN.
- Defined:
  - Adds an INDEX_BITS-wide global history register (GHR), reset to 0 and held at 0 during INIT.
  - On each RUN-state upd_valid: ghr <= {ghr[INDEX_BITS-2:0], upd_taken}.
  - Predict index = pc[INDEX_BITS+1:2] XOR ghr.
  - New output pred_ghr (INDEX_BITS) returns the GHR used for that prediction, aligned with pred_out_valid.
  - New input upd_ghr (INDEX_BITS); update index = upd_pc[INDEX_BITS+1:2] XOR upd_ghr.
  - Bypass compares the final XORed indices.
- Not defined: pred_ghr and upd_ghr ports do not exist; pure PC indexing.

Test Plan (WIDTH=2, INDEX_BITS=4, INIT_VAL=01):
- Reset/sweep: rst_n=0 for 2 cycles, then 1 -> busy=1 for exactly 16 cycles then 0; afterwards predicting pc=0x00..0x3C (step 4) returns pred_ctr=01, pred_taken=0 for every entry.
- Saturate up: 3 taken updates on pc=0x10 -> entry goes 10, 11, 11; predicting pc=0x10 -> pred_ctr=11, pred_taken=1 one cycle after request.
- Saturate down: 2 not-taken updates on pc=0x08 -> 00, 00; pred_ctr=00, pred_taken=0; a further taken update -> 01.
- Bypass/isolation: same-cycle upd_pc=0x20 taken and pred_pc=0x20 -> next-cycle pred_ctr=10; predicting pc=0x24 -> 01 (unaffected).
- Aliasing: taken updates on pc=0x04 twice -> predicting pc=0x44 returns 11, pred_taken=1.
- Reset mid-sweep/ignored inputs: drop rst_n at sweep cycle 5, release -> busy high 16 more cycles. upd_valid pulses during busy have no effect; pred_valid during busy gives pred_out_valid=0.

Source files
------------

// File: rtl/bht_sat_table_if.sv
// Predict/update bus between the fetch/execute stages and the branch history table.
// BHT_GSHARE_EN adds the global-history fields pred_ghr/upd_ghr.
interface bht_sat_table_if #(
   parameter int WIDTH = 2
`ifdef BHT_GSHARE_EN
   , parameter int INDEX_BITS = 6
`endif
);
   logic             pred_valid;
   logic [31:0]      pred_pc;
   logic             pred_out_valid;
   logic             pred_taken;
   logic [WIDTH-1:0] pred_ctr;
   logic             upd_valid;
   logic [31:0]      upd_pc;
   logic             upd_taken;
   logic             busy;
`ifdef BHT_GSHARE_EN
   logic [INDEX_BITS-1:0] pred_ghr;
   logic [INDEX_BITS-1:0] upd_ghr;

   modport master (
      output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_ghr,
      input  pred_out_valid, pred_taken, pred_ctr, busy, pred_ghr
   );
   modport slave (
      input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken, upd_ghr,
      output pred_out_valid, pred_taken, pred_ctr, busy, pred_ghr
   );
`else
   modport master (
      output pred_valid, pred_pc, upd_valid, upd_pc, upd_taken,
      input  pred_out_valid, pred_taken, pred_ctr, busy
   );
   modport slave (
      input  pred_valid, pred_pc, upd_valid, upd_pc, upd_taken,
      output pred_out_valid, pred_taken, pred_ctr, busy
   );
`endif
endinterface

// File: rtl/bht_sat_table.sv
// Branch history table of 2^INDEX_BITS saturating counters with registered predict,
// single-edge update, same-cycle bypass and an init sweep. Optional macro: BHT_GSHARE_EN.
module bht_sat_table #(
   parameter int               WIDTH      = 2,
   parameter int               INDEX_BITS = 6,
   parameter logic [WIDTH-1:0] INIT_VAL   = {1'b0, {(WIDTH-1){1'b1}}}
) (
   input logic             clk,
   input logic             rst_n,
   bht_sat_table_if.slave  bht
);
   localparam int                    DEPTH    = 1 << INDEX_BITS;
   localparam logic [WIDTH-1:0]      CTR_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]      CTR_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]      CTR_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [INDEX_BITS-1:0] PTR_ZERO = {INDEX_BITS{1'b0}};
   localparam logic [INDEX_BITS-1:0] PTR_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};
   localparam logic [INDEX_BITS-1:0] PTR_LAST = {INDEX_BITS{1'b1}};

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] cur, input logic up);
      logic [WIDTH-1:0] result;
      if (up) begin
         result = (cur == CTR_MAX) ? cur : cur + CTR_ONE;
      end else begin
         result = (cur == CTR_ZERO) ? cur : cur - CTR_ONE;
      end
      return result;
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic [INDEX_BITS-1:0] r_ptr;
   logic [WIDTH-1:0]      r_table [DEPTH];
   logic                  r_pred_out_valid;
   logic                  r_pred_taken;
   logic [WIDTH-1:0]      r_pred_ctr;
   logic [INDEX_BITS-1:0] w_pred_idx;
   logic [INDEX_BITS-1:0] w_upd_idx;
   logic [WIDTH-1:0]      w_upd_new;
   logic [WIDTH-1:0]      w_pred_val;
   logic                  w_bypass;
   logic                  w_run;
   logic                  w_unused_pc;

   assign w_run = (r_state == ST_RUN);
   assign w_unused_pc = ^{bht.pred_pc[31:INDEX_BITS+2], bht.pred_pc[1:0],
                          bht.upd_pc[31:INDEX_BITS+2], bht.upd_pc[1:0]};

`ifdef BHT_GSHARE_EN
   logic [INDEX_BITS-1:0] r_ghr;
   logic [INDEX_BITS-1:0] r_pred_ghr;

   assign w_pred_idx   = bht.pred_pc[INDEX_BITS+1:2] ^ r_ghr;
   assign w_upd_idx    = bht.upd_pc[INDEX_BITS+1:2] ^ bht.upd_ghr;
   assign bht.pred_ghr = r_pred_ghr;

   // Global history: cleared by reset, pinned to zero while sweeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ghr <= PTR_ZERO;
      end else if (!w_run) begin
         r_ghr <= PTR_ZERO;
      end else if (bht.upd_valid) begin
         r_ghr <= {r_ghr[INDEX_BITS-2:0], bht.upd_taken};
      end else begin
         r_ghr <= r_ghr;
      end
   end

   // History that produced the registered prediction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pred_ghr <= PTR_ZERO;
      end else if (w_run && bht.pred_valid) begin
         r_pred_ghr <= r_ghr;
      end else begin
         r_pred_ghr <= r_pred_ghr;
      end
   end
`else
   assign w_pred_idx = bht.pred_pc[INDEX_BITS+1:2];
   assign w_upd_idx  = bht.upd_pc[INDEX_BITS+1:2];
`endif

   assign w_upd_new = sat_step(r_table[w_upd_idx], bht.upd_taken);
   assign w_bypass  = bht.upd_valid && (w_pred_idx == w_upd_idx);

   // A colliding update forwards its new value so the prediction is never stale.
   always_comb begin
      w_pred_val = r_table[w_pred_idx];
      if (w_bypass) begin
         w_pred_val = w_upd_new;
      end else begin
         w_pred_val = r_table[w_pred_idx];
      end
   end

   // Sweep ends after the write to the last entry.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT: begin
            if (r_ptr == PTR_LAST) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_INIT;
            end
         end
         ST_RUN:  w_state_nxt = ST_RUN;
         default: w_state_nxt = ST_INIT;
      endcase
   end

   // State and sweep pointer; the pointer wraps back to zero as the sweep completes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_INIT;
         r_ptr   <= PTR_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_run ? r_ptr : r_ptr + PTR_ONE;
      end
   end

   // Table storage is deliberately not cleared by reset; the sweep rewrites it.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (!w_run) begin
            r_table[r_ptr] <= INIT_VAL;
         end else if (bht.upd_valid) begin
            r_table[w_upd_idx] <= w_upd_new;
         end
      end
   end

   // Registered prediction; value fields hold while no request is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pred_out_valid <= 1'b0;
         r_pred_taken     <= 1'b0;
         r_pred_ctr       <= CTR_ZERO;
      end else if (w_run && bht.pred_valid) begin
         r_pred_out_valid <= 1'b1;
         r_pred_taken     <= w_pred_val[WIDTH-1];
         r_pred_ctr       <= w_pred_val;
      end else begin
         r_pred_out_valid <= 1'b0;
         r_pred_taken     <= r_pred_taken;
         r_pred_ctr       <= r_pred_ctr;
      end
   end

   assign bht.pred_out_valid = r_pred_out_valid;
   assign bht.pred_taken     = r_pred_taken;
   assign bht.pred_ctr       = r_pred_ctr;
   assign bht.busy           = ~w_run;
endmodule
